// File: rtl/axi_llc_evict_ctrl.sv
// LLC miss eviction controller: picks a victim, writes it back if dirty,
// refills the line, updates the tag store and reports the filled way.
package axi_llc_pkg;
  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
  } llc_cfg_t;
endpackage

module axi_llc_evict_ctrl
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg        = llc_cfg_t'{default: '0},
  parameter type         way_ind_t  = logic,
  parameter int unsigned IndexWidth = 32'd8,
  parameter int unsigned TagWidth   = 32'd20
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [IndexWidth-1:0] miss_index_i,
  input  logic [TagWidth-1:0]   miss_tag_i,
  input  logic                  miss_write_i,
  output logic                  evict_req_o,
  input  logic                  evict_valid_i,
  input  way_ind_t              evict_way_i,
  input  logic                  evict_i,
  input  logic [TagWidth-1:0]   old_tag_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [IndexWidth-1:0] wb_index_o,
  output logic [TagWidth-1:0]   wb_tag_o,
  output way_ind_t              wb_way_o,
  output logic                  refill_valid_o,
  input  logic                  refill_ready_i,
  output logic [IndexWidth-1:0] refill_index_o,
  output logic [TagWidth-1:0]   refill_tag_o,
  output way_ind_t              refill_way_o,
  output logic                  tag_we_o,
  output logic [IndexWidth-1:0] tag_index_o,
  output logic [TagWidth-1:0]   tag_o,
  output way_ind_t              tag_way_o,
  output logic                  tag_dirty_o,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output way_ind_t              done_way_o,
  output logic                  busy_o
);

  if (Cfg.SetAssociativity != 0 &&
      Cfg.SetAssociativity != $bits(way_ind_t)) begin : g_cfg_err
    $error("way_ind_t width must equal Cfg.SetAssociativity");
  end

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WB,
    REFILL,
    TAG,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IndexWidth-1:0] index_q, index_d;
  logic [TagWidth-1:0]   tag_q, tag_d;
  logic [TagWidth-1:0]   old_tag_q, old_tag_d;
  logic                  write_q, write_d;
  way_ind_t              way_q, way_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      index_q   <= '0;
      tag_q     <= '0;
      old_tag_q <= '0;
      write_q   <= 1'b0;
      way_q     <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      tag_q     <= tag_d;
      old_tag_q <= old_tag_d;
      write_q   <= write_d;
      way_q     <= way_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    tag_d          = tag_q;
    old_tag_d      = old_tag_q;
    write_d        = write_q;
    way_d          = way_q;
    miss_ready_o   = 1'b0;
    evict_req_o    = 1'b0;
    wb_valid_o     = 1'b0;
    wb_index_o     = '0;
    wb_tag_o       = '0;
    wb_way_o       = '0;
    refill_valid_o = 1'b0;
    refill_index_o = '0;
    refill_tag_o   = '0;
    refill_way_o   = '0;
    tag_we_o       = 1'b0;
    tag_index_o    = '0;
    tag_o          = '0;
    tag_way_o      = '0;
    tag_dirty_o    = 1'b0;
    done_valid_o   = 1'b0;
    done_way_o     = '0;
    unique case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          index_d = miss_index_i;
          tag_d   = miss_tag_i;
          write_d = miss_write_i;
          state_d = SELECT;
        end
      end
      SELECT: begin
        evict_req_o = 1'b1;
        if (evict_valid_i) begin
          way_d     = evict_way_i;
          old_tag_d = old_tag_i;
          state_d   = evict_i ? WB : REFILL;
        end
      end
      WB: begin
        wb_valid_o = 1'b1;
        wb_index_o = index_q;
        wb_tag_o   = old_tag_q;
        wb_way_o   = way_q;
        if (wb_ready_i) state_d = REFILL;
      end
      REFILL: begin
        refill_valid_o = 1'b1;
        refill_index_o = index_q;
        refill_tag_o   = tag_q;
        refill_way_o   = way_q;
        if (refill_ready_i) state_d = TAG;
      end
      TAG: begin
        tag_we_o    = 1'b1;
        tag_index_o = index_q;
        tag_o       = tag_q;
        tag_way_o   = way_q;
        tag_dirty_o = write_q;
        state_d     = DONE;
      end
      DONE: begin
        done_valid_o = 1'b1;
        done_way_o   = way_q;
        if (done_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // A selector returning a non-onehot way would corrupt two ways at once.
  a_way_onehot: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state_q inside {WB, REFILL, TAG, DONE}) |-> $onehot(way_q)
  ) else $fatal(1, "latched way is not onehot");

endmodule
